mmio_host_req: RTL and testbench

MMIO_HOST_REQ -- requirements
Module: mmio_host_req

---
 rtl/ccip_if_pkg.sv | 61 ++++++
 rtl/mmio_host_pkg.sv | 6 +
 rtl/mmio_host_req.sv | 82 ++++++++
 tb/tb_mmio_host_req.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ccip_if_pkg.sv
// ccip_if_pkg: CCI-P interface types shared by the platform (reduced to the channels this slice touches).
package ccip_if_pkg;
    typedef logic [15:0]  t_ccip_mmioAddr;
    typedef logic [8:0]   t_ccip_tid;
    typedef logic [511:0] t_ccip_clData;
    typedef logic [63:0]  t_ccip_mmioData;

    typedef struct packed {
        t_ccip_mmioAddr address;
        logic [1:0]     length;
        logic           rsvd;
        t_ccip_tid      tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_tid tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        t_ccip_clData        data;
        logic                rspValid;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [27:0] hdr;
        logic        rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [73:0] hdr;
        logic        valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        logic [79:0]  hdr;
        t_ccip_clData data;
        logic         valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        t_ccip_mmioData      data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;
endpackage

// File: rtl/mmio_host_pkg.sv
// mmio_host_pkg: FSM states and constants for the MMIO host request block.
package mmio_host_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESP} state_t;
    localparam logic [1:0] MMIO_LEN_8B = 2'b01;
    localparam int TIMEOUT_DEFAULT = 256;
endpackage

// File: rtl/mmio_host_req.sv
// mmio_host_req: issues MMIO requests on CCI-P Rx c0 and collects c2 read responses with a timeout.
module mmio_host_req
    import mmio_host_pkg::*;
    import ccip_if_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int TID_W = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [63:0] cmd_wdata,
    output t_if_ccip_Rx rx_out,
    input  t_if_ccip_Tx tx_in,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic        rsp_timeout,
    output logic        busy
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    state_t           state, next;
    logic [CNT_W-1:0] cnt;
    logic [TID_W-1:0] tid;
    logic             accept, match, expired, done, unused_tx;
    t_if_ccip_Rx      rx_d;

    assign unused_tx = ^tx_in;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= next;

    // The request is built straight from the command so it is on rx_out in the ISSUE cycle.
    always_comb begin
        accept = cmd_valid && cmd_ready;
        match = state == WAIT_RSP && tx_in.c2.mmioRdValid && tx_in.c2.hdr.tid == t_ccip_tid'(tid);
        expired = state == WAIT_RSP && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
        done = match || expired;
        next = state;
        case (state)
            IDLE:     next = accept ? ISSUE : IDLE;
            ISSUE:    next = rx_out.c0.mmioWrValid ? IDLE : WAIT_RSP;
            WAIT_RSP: next = done ? RESP : WAIT_RSP;
            default:  next = IDLE;
        endcase
        rx_d = '0;
        if (accept) begin
            rx_d.c0.hdr.address = cmd_addr;
            rx_d.c0.hdr.length = MMIO_LEN_8B;
            rx_d.c0.hdr.tid = t_ccip_tid'(tid);
            rx_d.c0.data = t_ccip_clData'(cmd_wdata);
            rx_d.c0.mmioWrValid = cmd_write;
            rx_d.c0.mmioRdValid = !cmd_write;
        end
    end

    // The TID advances only when a read completes or times out, so the pending TID stays stable in WAIT_RSP.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rx_out <= '0;
            cmd_ready <= 1'b0;
            busy <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data <= '0;
            rsp_timeout <= 1'b0;
            tid <= '0;
            cnt <= '0;
        end else begin
            rx_out <= rx_d;
            cmd_ready <= next == IDLE;
            busy <= next != IDLE;
            rsp_valid <= done;
            rsp_data <= match ? tx_in.c2.data : '0;
            rsp_timeout <= done && !match;
            cnt <= state == WAIT_RSP ? cnt + 1'b1 : '0;
            if (done) tid <= tid + 1'b1;
        end
endmodule

// File: tb/tb_mmio_host_req.sv
// tb_mmio_host_req: directed and randomized checks of mmio_host_req against a transaction-level model.
module tb_mmio_host_req;
    import ccip_if_pkg::*;

    localparam int T = 32;

    logic        clk = 1'b0;
    logic        rst, cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_timeout, busy;
    logic [15:0] cmd_addr;
    logic [63:0] cmd_wdata, rsp_data;
    t_if_ccip_Rx rx_out;
    t_if_ccip_Tx tx_in;
    int          checks = 0, errors = 0, exp_tid = 0;

    always #5 clk = ~clk;

    mmio_host_req #(.TIMEOUT_CYCLES(T), .TID_W(9)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rx_out(rx_out), .tx_in(tx_in), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_c2(input bit v, input int t, input logic [63:0] d);
        tx_in = '0;
        tx_in.c2.mmioRdValid = v;
        tx_in.c2.hdr.tid = 9'(t);
        tx_in.c2.data = d;
    endtask

    // Offers one command and checks the request visible in the cycle after acceptance.
    task automatic issue(input bit wr, input logic [15:0] a, input logic [63:0] d);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            tick;
            n++;
        end
        chk("ready_wait", cmd_ready, 1);
        cmd_valid = 1;
        cmd_write = wr;
        cmd_addr = a;
        cmd_wdata = d;
        tick;
        cmd_valid = 0;
        cmd_write = 1'($urandom);
        cmd_addr = 16'($urandom);
        cmd_wdata = {$urandom, $urandom};
        chk("wr_valid", rx_out.c0.mmioWrValid, wr);
        chk("rd_valid", rx_out.c0.mmioRdValid, !wr);
        chk("hdr_addr", rx_out.c0.hdr.address, a);
        chk("hdr_len", rx_out.c0.hdr.length, 2'b01);
        chk("c0_data", rx_out.c0.data[63:0], d);
        chk("c0_data_hi", rx_out.c0.data[511:64] == '0, 1);
        chk("issue_busy", busy, 1);
        chk("issue_ready", cmd_ready, 0);
        if (!wr) chk("hdr_tid", rx_out.c0.hdr.tid, 64'(exp_tid));
    endtask

    task automatic do_write(input logic [15:0] a, input logic [63:0] d);
        issue(1, a, d);
        tick;
        chk("wr_pulse_end", rx_out.c0.mmioWrValid, 0);
        chk("wr_ready", cmd_ready, 1);
        chk("wr_busy", busy, 0);
        chk("wr_no_rsp", rsp_valid, 0);
    endtask

    // Model: the first response carrying the pending TID within WAIT cycles 0..T-1 completes the read;
    // otherwise the read times out and reports after WAIT cycle T-1.
    task automatic do_read(input logic [15:0] a, input int match_at, input int junk_at,
                           input int junk_off, input bit early, input logic [63:0] d);
        bit hit = match_at >= 0 && match_at < T;
        int exp_k = hit ? match_at : T - 1;
        issue(0, a, {$urandom, $urandom});
        if (early) drive_c2(1, exp_tid, ~d);
        else drive_c2(0, exp_tid, {$urandom, $urandom});
        tick;
        for (int k = 0; k <= exp_k; k++) begin
            if (k == match_at) drive_c2(1, exp_tid, d);
            else if (k == junk_at) drive_c2(1, (exp_tid + junk_off) % 512, ~d);
            else drive_c2(0, exp_tid, {$urandom, $urandom});
            chk("wait_no_rsp", rsp_valid, 0);
            tick;
        end
        drive_c2(0, 0, 0);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_timeout", rsp_timeout, !hit);
        chk("rsp_data", rsp_data, hit ? d : 64'h0);
        chk("rsp_busy", busy, 1);
        tick;
        chk("rsp_pulse_end", rsp_valid, 0);
        chk("rsp_ready", cmd_ready, 1);
        exp_tid = (exp_tid + 1) % 512;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx"}, rx_out == '0, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int old_tid;
        rst = 1;
        cmd_valid = 0;
        cmd_write = 0;
        cmd_addr = '0;
        cmd_wdata = '0;
        tx_in = '0;
        tick;
        tick;
        chk_all_zero("reset");
        chk("reset_ready", cmd_ready, 0);
        rst = 0;
        tick;
        chk("ready_after_reset", cmd_ready, 1);

        do_write(16'h0020, 64'hDEAD_BEEF_0123_4567);
        do_read(16'h0002, 5, -1, 1, 0, 64'hA5A5);
        do_read(16'h0010, -1, 3, 1, 0, 64'h1111);
        do_read(16'h0011, T - 1, 4, 1, 0, 64'h2222_3333);
        do_read(16'h0012, T, -1, 1, 0, 64'h4444);
        do_write(16'h0100, 64'h5555);
        do_read(16'h0013, -1, 0, 511, 0, 64'h6666);
        do_read(16'h0014, 2, 1, 511, 1, 64'h7777_8888_9999_AAAA);
        do_read(16'h0015, 0, -1, 1, 1, 64'hBBBB);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) do_write(16'($urandom), {$urandom, $urandom});
            else do_read(16'($urandom), $urandom_range(0, T + 2) - 1, $urandom_range(0, T) - 1,
                         ($urandom_range(0, 1) == 1) ? 1 : 511, 1'($urandom), {$urandom, $urandom});
        end

        old_tid = exp_tid;
        issue(0, 16'h0040, 64'h0);
        tick;
        tick;
        tick;
        rst = 1;
        #1;
        chk_all_zero("abort");
        tick;
        tick;
        rst = 0;
        exp_tid = 0;
        drive_c2(1, old_tid, 64'h1234);
        tick;
        chk("abort_ready", cmd_ready, 1);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_rsp", rsp_valid, 0);
            chk("abort_busy", busy, 0);
            tick;
        end
        drive_c2(0, 0, 0);

        for (int i = 0; i < 513; i++)
            do_read(16'(i), $urandom_range(0, 3), -1, 1, 0, {$urandom, 32'(i)});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
